// File: rtl/lcd_row_animator_if.sv
// Button pulses into the row animator and its registered display/status outputs.
// btn_pressed bits are single-cycle pulses with no handshake; every output is a plain registered level except step.
interface lcd_row_animator_if #(
  parameter int N_CHARS = 16
);
  logic [3:0]           btn_pressed;
  logic [8*N_CHARS-1:0] row_A;
  logic [8*N_CHARS-1:0] row_B;
  logic                 running;
  logic                 mode;
  logic                 dir;
  logic [1:0]           speed;
  logic                 step;

  modport slave (
    input  btn_pressed,
    output row_A, row_B, running, mode, dir, speed, step
  );

  modport master (
    output btn_pressed,
    input  row_A, row_B, running, mode, dir, speed, step
  );
endinterface

// File: rtl/lcd_row_animator.sv
// Two-row character animator for the LCD row buffers: run/pause, letter-cycle or
// rotate mode, direction reversal and four speed levels driven by button pulses.
module lcd_row_animator #(
  parameter int         N_CHARS     = 16,
  parameter int         TICK_CYCLES = 100000000,
  parameter logic [7:0] CHAR_LO     = 8'h41,
  parameter logic [7:0] CHAR_HI     = 8'h5A
) (
  input  logic clk,
  input  logic reset_n,
  lcd_row_animator_if.slave bus
);
  localparam int RW = 8 * N_CHARS;
  localparam int CW = $clog2(TICK_CYCLES + 1);
  localparam int R  = int'(CHAR_HI) - int'(CHAR_LO) + 1;

  logic [RW-1:0] row_a_q, row_b_q, row_a_d, row_b_d;
  logic          running_q, mode_q, dir_q, step_q;
  logic [1:0]    speed_q;
  logic [CW-1:0] cnt_q, cnt_d, period;
  logic          start, stop, term, do_step;

  function automatic logic [RW-1:0] init_row(input int offset);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < N_CHARS; i++)
      r[RW-1-8*i -: 8] = CHAR_LO + 8'((i + offset) % R);
    return r;
  endfunction

  function automatic logic [7:0] inc_char(input logic [7:0] c);
    return (c >= CHAR_HI) ? CHAR_LO : c + 8'd1;
  endfunction

  function automatic logic [7:0] dec_char(input logic [7:0] c);
    return (c <= CHAR_LO) ? CHAR_HI : c - 8'd1;
  endfunction

  function automatic logic [RW-1:0] cycle_row(input logic [RW-1:0] r, input logic up);
    logic [RW-1:0] o;
    o = '0;
    for (int i = 0; i < N_CHARS; i++)
      o[8*i +: 8] = up ? inc_char(r[8*i +: 8]) : dec_char(r[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [RW-1:0] rot_left(input logic [RW-1:0] r);
    return {r[RW-9:0], r[RW-1 -: 8]};
  endfunction

  function automatic logic [RW-1:0] rot_right(input logic [RW-1:0] r);
    return {r[7:0], r[RW-1:8]};
  endfunction

  // A pause press holds the counter; the next start clears it anyway.
  always_comb begin
    period  = CW'(TICK_CYCLES >> speed_q);
    start   = bus.btn_pressed[0] & ~running_q;
    stop    = bus.btn_pressed[0] & running_q;
    term    = running_q && (cnt_q == period - CW'(1));
    do_step = term & ~bus.btn_pressed[0] & ~bus.btn_pressed[3];

    cnt_d = cnt_q;
    if (bus.btn_pressed[3] || start)
      cnt_d = '0;
    else if (running_q && !stop)
      cnt_d = do_step ? '0 : cnt_q + CW'(1);

    row_a_d = row_a_q;
    row_b_d = row_b_q;
    if (do_step) begin
      if (mode_q) begin
        row_a_d = dir_q ? rot_right(row_a_q) : rot_left(row_a_q);
        row_b_d = dir_q ? rot_left(row_b_q)  : rot_right(row_b_q);
      end else begin
        row_a_d = cycle_row(row_a_q, ~dir_q);
        row_b_d = cycle_row(row_b_q, dir_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      running_q <= 1'b0;
      mode_q    <= 1'b0;
      dir_q     <= 1'b0;
      speed_q   <= 2'd0;
      step_q    <= 1'b0;
      cnt_q     <= '0;
      row_a_q   <= init_row(0);
      row_b_q   <= init_row(N_CHARS);
    end else begin
      running_q <= running_q ^ bus.btn_pressed[0];
      mode_q    <= mode_q ^ bus.btn_pressed[1];
      dir_q     <= dir_q ^ bus.btn_pressed[2];
      speed_q   <= speed_q + {1'b0, bus.btn_pressed[3]};
      step_q    <= do_step;
      cnt_q     <= cnt_d;
      row_a_q   <= row_a_d;
      row_b_q   <= row_b_d;
    end
  end

  assign bus.row_A   = row_a_q;
  assign bus.row_B   = row_b_q;
  assign bus.running = running_q;
  assign bus.mode    = mode_q;
  assign bus.dir     = dir_q;
  assign bus.speed   = speed_q;
  assign bus.step    = step_q;
endmodule

// File: tb/tb_lcd_row_animator.sv
// Bench for lcd_row_animator with TICK_CYCLES=10: control table, step scoreboard
// (expected cycle and rows per step) and hand-written multi-cycle sequences.
module tb_lcd_row_animator;
  localparam int N    = 16;
  localparam int TICK = 10;
  localparam int RW   = 8 * N;
  localparam int SW   = 32 + 2 * RW;
  localparam int LO   = 8'h41;
  localparam int R    = 26;

  localparam logic [RW-1:0] RST_A  = "ABCDEFGHIJKLMNOP";
  localparam logic [RW-1:0] RST_B  = "QRSTUVWXYZABCDEF";
  localparam logic [RW-1:0] CYC1_A = "BCDEFGHIJKLMNOPQ";
  localparam logic [RW-1:0] CYC1_B = "PQRSTUVWXYZABCDE";
  localparam logic [RW-1:0] ROT_A  = "BCDEFGHIJKLMNOPA";
  localparam logic [RW-1:0] ROT_B  = "FQRSTUVWXYZABCDE";

  typedef struct {
    logic [3:0] btn;
    logic       exp_mode;
    logic       exp_dir;
    logic [1:0] exp_speed;
  } ctl_vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            k_steps;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] mon_e;
  ctl_vec_t      tbl[9];

  lcd_row_animator_if #(.N_CHARS(N)) bus();

  lcd_row_animator #(
    .N_CHARS(N), .TICK_CYCLES(TICK), .CHAR_LO(8'h41), .CHAR_HI(8'h5A)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] b);
    bus.btn_pressed = b;
    tick(1);
    bus.btn_pressed = 4'h0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.btn_pressed = 4'h0;
    tick(2);
    reset_n = 1'b1;
  endtask

  // Letter-cycle expectation written as modular arithmetic on the alphabet index.
  function automatic logic [RW-1:0] cyc_row(input logic [RW-1:0] base, input int delta);
    logic [RW-1:0] r;
    int off;
    r = '0;
    for (int i = 0; i < N; i++) begin
      off = (int'(base[RW-1-8*i -: 8]) - LO + delta) % R;
      if (off < 0) off += R;
      r[RW-1-8*i -: 8] = 8'(LO + off);
    end
    return r;
  endfunction

  task automatic expect_step(input int at, input logic [RW-1:0] a, input logic [RW-1:0] b);
    exp_q.push_back({32'(at), a, b});
  endtask

  task automatic expect_cycle_step(input int at);
    k_steps++;
    expect_step(at, cyc_row(RST_A, k_steps), cyc_row(RST_B, -k_steps));
  endtask

  task automatic chk_ctl(input string name, input logic run, input logic m,
                         input logic d, input logic [1:0] s);
    chk({name, "_running"}, RW'(bus.running), RW'(run));
    chk({name, "_mode"},    RW'(bus.mode),    RW'(m));
    chk({name, "_dir"},     RW'(bus.dir),     RW'(d));
    chk({name, "_speed"},   RW'(bus.speed),   RW'(s));
  endtask

  // Every step pulse must match the head of the queue in cycle and row contents.
  always @(posedge clk) begin
    #1;
    if (bus.step === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step at cycle %0d: step=1 required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("step_cycle", RW'(cyc), RW'(mon_e[SW-1 -: 32]));
        chk("step_row_A", bus.row_A, mon_e[2*RW-1:RW]);
        chk("step_row_B", bus.row_B, mon_e[RW-1:0]);
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][SW-1 -: 32]) <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_step: no step at cycle %0d, required at %0d", cyc, int'(mon_e[SW-1 -: 32]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3, c4;
    tbl[0] = '{4'h2, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{4'h4, 1'b1, 1'b1, 2'd0};
    tbl[2] = '{4'h8, 1'b1, 1'b1, 2'd1};
    tbl[3] = '{4'h8, 1'b1, 1'b1, 2'd2};
    tbl[4] = '{4'h8, 1'b1, 1'b1, 2'd3};
    tbl[5] = '{4'h8, 1'b1, 1'b1, 2'd0};
    tbl[6] = '{4'hE, 1'b0, 1'b0, 2'd1};
    tbl[7] = '{4'h0, 1'b0, 1'b0, 2'd1};
    tbl[8] = '{4'hA, 1'b1, 1'b0, 2'd2};

    bus.btn_pressed = 4'h0;
    k_steps = 0;

    // Reset state and idle
    do_reset();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset_step", RW'(bus.step), RW'(1'b0));
    chk("reset_row_A", bus.row_A, RST_A);
    chk("reset_row_B", bus.row_B, RST_B);
    tick(50);
    chk("idle_row_A", bus.row_A, RST_A);
    chk("idle_row_B", bus.row_B, RST_B);
    chk("idle_running", RW'(bus.running), RW'(1'b0));

    // Control table while paused: rows must stay frozen
    for (int i = 0; i < 9; i++) begin
      pulse(tbl[i].btn);
      chk_ctl($sformatf("tbl%0d", i), 1'b0, tbl[i].exp_mode, tbl[i].exp_dir, tbl[i].exp_speed);
      chk($sformatf("tbl%0d_row_A", i), bus.row_A, RST_A);
    end

    // CYCLE mode, ten steps through the Z->A wrap
    do_reset();
    pulse(4'h1);
    c0 = cyc;
    chk("cycle_running", RW'(bus.running), RW'(1'b1));
    expect_step(c0 + TICK, CYC1_A, CYC1_B);
    k_steps = 1;
    for (int k = 2; k <= 10; k++) expect_cycle_step(c0 + TICK * k);
    wait_until(c0 + 10 * TICK);
    pulse(4'h1);
    chk("cycle_b10", RW'(bus.row_B[47:40]), RW'(8'h51));
    chk("cycle_paused", RW'(bus.running), RW'(1'b0));

    // ROTATE mode and direction reversal
    do_reset();
    pulse(4'h2);
    pulse(4'h1);
    c0 = cyc;
    expect_step(c0 + TICK, ROT_A, ROT_B);
    wait_until(c0 + TICK);
    pulse(4'h4);
    expect_step(c0 + 2 * TICK, RST_A, RST_B);
    wait_until(c0 + 2 * TICK);
    pulse(4'h1);
    chk_ctl("rotate_end", 1'b0, 1'b1, 1'b1, 2'd0);

    // Speed cycling: spacing 10, 5, 2, 1, back to 10
    do_reset();
    k_steps = 0;
    pulse(4'h1);
    c0 = cyc;
    expect_cycle_step(c0 + TICK);
    wait_until(c0 + TICK);
    pulse(4'h8);
    c1 = cyc;
    chk("speed1", RW'(bus.speed), RW'(2'd1));
    expect_cycle_step(c1 + 5);
    expect_cycle_step(c1 + 10);
    wait_until(c1 + 10);
    pulse(4'h8);
    c2 = cyc;
    chk("speed2", RW'(bus.speed), RW'(2'd2));
    for (int k = 1; k <= 3; k++) expect_cycle_step(c2 + 2 * k);
    wait_until(c2 + 6);
    pulse(4'h8);
    c3 = cyc;
    chk("speed3", RW'(bus.speed), RW'(2'd3));
    for (int k = 1; k <= 3; k++) expect_cycle_step(c3 + k);
    wait_until(c3 + 3);
    pulse(4'h8);
    c4 = cyc;
    chk("speed0", RW'(bus.speed), RW'(2'd0));
    expect_cycle_step(c4 + TICK);
    wait_until(c4 + TICK);
    pulse(4'h1);

    // Pause on the terminal-count edge, then simultaneous start+mode
    do_reset();
    pulse(4'h1);
    c0 = cyc;
    wait_until(c0 + TICK - 1);
    pulse(4'h1);
    chk("pause_tc_running", RW'(bus.running), RW'(1'b0));
    chk("pause_tc_step", RW'(bus.step), RW'(1'b0));
    tick(30);
    chk("frozen_row_A", bus.row_A, RST_A);
    chk("frozen_row_B", bus.row_B, RST_B);
    pulse(4'h3);
    c1 = cyc;
    chk_ctl("simul", 1'b1, 1'b1, 1'b0, 2'd0);
    expect_step(c1 + TICK, ROT_A, ROT_B);
    wait_until(c1 + TICK);
    pulse(4'h1);

    // Reset on a terminal-count edge with all buttons pressed
    do_reset();
    pulse(4'h1);
    c0 = cyc;
    wait_until(c0 + TICK - 1);
    reset_n = 1'b0;
    bus.btn_pressed = 4'hF;
    tick(1);
    reset_n = 1'b1;
    bus.btn_pressed = 4'h0;
    chk("midrst_step", RW'(bus.step), RW'(1'b0));
    chk_ctl("midrst", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("midrst_row_A", bus.row_A, RST_A);
    chk("midrst_row_B", bus.row_B, RST_B);
    tick(15);
    chk("midrst_after_running", RW'(bus.running), RW'(1'b0));

    tick(2);
    chk("scoreboard_empty", RW'(exp_q.size()), RW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
